// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} div_state_t;

  localparam int unsigned DEF_WIDTH = 64;

  // Counter width needed to count 0..width iterations
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the execute stage and the divider.
interface seq_divider_if #(parameter int unsigned WIDTH = 64);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift {rem,num} left, trial-subtract, emit a quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] num_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] num_c
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             q_bit;

  // Trial is WIDTH+1 bits since the shifted remainder can exceed the divisor width
  always_comb begin
    trial = {rem_i, num_i[WIDTH-1]};
    q_bit = (trial >= {1'b0, dvs_i});
    diff  = WIDTH'(trial - {1'b0, dvs_i});
    rem_c = q_bit ? diff : trial[WIDTH-1:0];
    num_c = {num_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Signed (SDIV) support is compiled in with `define SEQ_DIVIDER_SIGNED_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int unsigned         CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_IT  = CNT_BITS'(WIDTH - 1);

  div_state_t          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    num_q, num_d;
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic [WIDTH-1:0]    quotient_q, quotient_d;
  logic [WIDTH-1:0]    remainder_q, remainder_d;
  logic [WIDTH-1:0]    step_rem_c, step_num_c;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic sd_c, sv_c;
`else
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .num_i (num_q),
    .dvs_i (dvs_q),
    .rem_c (step_rem_c),
    .num_c (step_num_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    num_d       = num_q;
    dvs_d       = dvs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    sd_c        = bus.is_signed & bus.dividend[WIDTH-1];
    sv_c        = bus.is_signed & bus.divisor[WIDTH-1];
`endif

    case (state_q)
      IDLE: begin
        // busy is still high during the done cycle, which blocks a same-cycle start
        busy_d = 1'b0;
        if (bus.start && !busy_q) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          rem_d  = '0;
          if (bus.divisor == '0) begin
            num_d   = bus.dividend;
            dvs_d   = '0;
            state_d = ZERO;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            num_d     = sd_c ? -bus.dividend : bus.dividend;
            dvs_d     = sv_c ? -bus.divisor  : bus.divisor;
            neg_quo_d = sd_c ^ sv_c;
            neg_rem_d = sd_c;
`else
            num_d     = bus.dividend;
            dvs_d     = bus.divisor;
`endif
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem_c;
        num_d = step_num_c;
        cnt_d = cnt_q + CNT_BITS'(1);
        if (cnt_q == LAST_IT) state_d = FIX;
      end
      FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        quotient_d  = neg_quo_q ? -num_q : num_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
`else
        quotient_d  = num_q;
        remainder_d = rem_q;
`endif
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        quotient_d  = '0;
        remainder_d = num_q;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      num_q       <= '0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      num_q       <= num_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider; signed vectors run when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int unsigned W   = 64;
  localparam int          LAT = W + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Called at a negedge: raise start for one edge, return at the next negedge (cycle 1 after accept)
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
    lat     = lat0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 300) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      errs++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
    end
    vecs++;
    if (bus.quotient !== '0 || bus.remainder !== '0) begin
      errs++; $display("FAIL reset_results: got q=%0d r=%0d want 0/0", bus.quotient, bus.remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat; bit bok;
    issue(64'd20, 64'd5, 1'b0);
    wait_done(1, lat, bok);
    vecs++;
    if (lat !== LAT) begin errs++; $display("FAIL u20_5_latency: got %0d want %0d", lat, LAT); end
    vecs++;
    if (!bok) begin errs++; $display("FAIL u20_5_busy: busy dropped before done"); end
    vecs++;
    if (bus.quotient !== 64'd4 || bus.remainder !== 64'd0 || bus.div_by_zero !== 1'b0) begin
      errs++; $display("FAIL u20_5_result: got q=%0d r=%0d z=%b want 4 0 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    vecs++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 64'd4) begin
      errs++; $display("FAIL u20_5_after: got done=%b busy=%b q=%0d want 0 0 4", bus.done, bus.busy, bus.quotient);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [3] = '{64'd2000, 64'd19, 64'd34};
    logic [W-1:0] b [3] = '{64'd50, 64'd6, 64'd3};
    logic [W-1:0] q [3] = '{64'd40, 64'd3, 64'd11};
    logic [W-1:0] r [3] = '{64'd0, 64'd1, 64'd1};
    int lat; bit bok;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        // Hold start through the done cycle; it must only be taken the cycle after
        bus.start = 1'b1; bus.dividend = a[i]; bus.divisor = b[i];
        @(negedge clk);
      end
      issue(a[i], b[i], 1'b0);
      wait_done(1, lat, bok);
      vecs++;
      if (lat !== LAT || !bok) begin
        errs++; $display("FAIL b2b_%0d_timing: got lat=%0d busy_ok=%0d want %0d 1", i, lat, bok, LAT);
      end
      vecs++;
      if (bus.quotient !== q[i] || bus.remainder !== r[i]) begin
        errs++; $display("FAIL b2b_%0d_result: got q=%0d r=%0d want %0d %0d", i, bus.quotient, bus.remainder, q[i], r[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat; bit bok;
    issue(64'd123, 64'd0, 1'b0);
    wait_done(1, lat, bok);
    vecs++;
    if (lat !== 2 || !bok) begin errs++; $display("FAIL dbz_timing: got lat=%0d busy_ok=%0d want 2 1", lat, bok); end
    vecs++;
    if (bus.quotient !== 64'd0 || bus.remainder !== 64'd123 || bus.div_by_zero !== 1'b1) begin
      errs++; $display("FAIL dbz_result: got q=%0d r=%0d z=%b want 0 123 1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    issue(64'd9, 64'd3, 1'b0);
    vecs++;
    if (bus.div_by_zero !== 1'b1) begin errs++; $display("FAIL dbz_held: got z=%b want 1", bus.div_by_zero); end
    wait_done(1, lat, bok);
    vecs++;
    if (lat !== LAT || bus.quotient !== 64'd3 || bus.remainder !== 64'd0 || bus.div_by_zero !== 1'b0) begin
      errs++; $display("FAIL dbz_clear: got lat=%0d q=%0d r=%0d z=%b want %0d 3 0 0", lat, bus.quotient, bus.remainder, bus.div_by_zero, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_is_signed_mode();
    int lat; bit bok;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic [W-1:0] a [3] = '{-64'sd7, 64'd7, 64'h8000_0000_0000_0000};
    logic [W-1:0] b [3] = '{64'd2, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [W-1:0] q [3] = '{-64'sd3, -64'sd3, 64'h8000_0000_0000_0000};
    logic [W-1:0] r [3] = '{-64'sd1, 64'd1, 64'd0};
    for (int i = 0; i < 3; i++) begin
      issue(a[i], b[i], 1'b1);
      wait_done(1, lat, bok);
      vecs++;
      if (lat !== LAT || bus.quotient !== q[i] || bus.remainder !== r[i] || bus.div_by_zero !== 1'b0) begin
        errs++; $display("FAIL signed_%0d: got lat=%0d q=%0h r=%0h z=%b want %0d %0h %0h 0", i, lat, bus.quotient, bus.remainder, bus.div_by_zero, LAT, q[i], r[i]);
      end
      @(negedge clk);
    end
`else
    // is_signed ignored: -7 is the raw pattern 2^64-7
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    wait_done(1, lat, bok);
    vecs++;
    if (lat !== LAT || bus.quotient !== 64'h7FFF_FFFF_FFFF_FFFC || bus.remainder !== 64'd1) begin
      errs++; $display("FAIL unsigned_ignore: got lat=%0d q=%0h r=%0h want %0d 7ffffffffffffffc 1", lat, bus.quotient, bus.remainder, LAT);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_start_ignored();
    int lat; bit bok;
    issue(64'd1000, 64'd7, 1'b0);
    lat = 1;
    repeat (10) begin @(negedge clk); lat++; end
    issue(64'd5, 64'd1, 1'b0);
    lat++;
    wait_done(lat, lat, bok);
    vecs++;
    if (lat !== LAT || !bok) begin errs++; $display("FAIL midrun_start_timing: got lat=%0d busy_ok=%0d want %0d 1", lat, bok, LAT); end
    vecs++;
    if (bus.quotient !== 64'd142 || bus.remainder !== 64'd6) begin
      errs++; $display("FAIL midrun_start_result: got q=%0d r=%0d want 142 6", bus.quotient, bus.remainder);
    end
    @(negedge clk);
    vecs++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL midrun_start_queued: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit bok; bit seen;
    issue(64'd500, 64'd3, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vecs++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
      errs++; $display("FAIL midrun_reset_clear: got busy=%b done=%b z=%b q=%0d r=%0d want all 0", bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    seen = 1'b0;
    repeat (LAT + 4) begin @(negedge clk); if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1; end
    vecs++;
    if (seen) begin errs++; $display("FAIL midrun_reset_nodone: got activity after reset want none"); end
    issue(64'd100, 64'd7, 1'b0);
    wait_done(1, lat, bok);
    vecs++;
    if (lat !== LAT || bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin
      errs++; $display("FAIL post_reset_100_7: got lat=%0d q=%0d r=%0d want %0d 14 2", lat, bus.quotient, bus.remainder, LAT);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_div_zero();
    test_is_signed_mode();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider for the LEGv8 datapath. It replaces the purely combinational 32-bit divider with a shift-subtract (restoring) engine that produces one quotient bit per clock, behind a start/done handshake. It returns both quotient and remainder, flags divide-by-zero, and optionally supports signed (SDIV) operation. The execute stage stalls on `busy` while a divide is in flight.

## Interface
- `WIDTH`, 64, operand/result width in bits (≥ 4)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request; accepted only when `busy`=0
- `is_signed`  in  1  sampled with `start`; 1 = two's-complement divide (ignored, treated as 0, when signed support is compiled out)
- `dividend`  in  WIDTH  numerator, sampled on accepted `start`
- `divisor`  in  WIDTH  denominator, sampled on accepted `start`
- `busy`  out  1  high from the cycle after acceptance until `done`
- `done`  out  1  one-cycle pulse: results valid
- `quotient`  out  WIDTH  held until the next accepted `start`
- `remainder`  out  WIDTH  held until the next accepted `start`
- `div_by_zero`  out  1  qualifies the current results; held with them

## Operation
- Reset: state IDLE; `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
- States: IDLE → RUN → FIX → IDLE; IDLE → ZERO → IDLE.
- IDLE: on `start`, latch the operands. If `divisor`==0, go to ZERO; otherwise take absolute values (signed mode only), record the result signs, clear the partial remainder and the counter, and go to RUN.
- RUN: each cycle, shift {rem, num} left by 1. If rem ≥ |divisor|, then rem −= |divisor| and shift in quotient bit 1, else bit 0. The counter increments; after WIDTH iterations, go to FIX.
- FIX: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend. Drive the outputs, pulse `done`, return to IDLE.
- ZERO: `quotient`=0, `remainder`=`dividend`, `div_by_zero`=1, pulse `done`, return to IDLE.
- Signed overflow, most-negative ÷ −1: `quotient` = most-negative value, `remainder` = 0, no flag. This falls out of WIDTH-bit wraparound and needs no special case.
- Unsigned: operands are taken raw; there are no sign corrections.
- `start` while `busy`: ignored. There is no queueing and the in-flight operation is unaffected.
- `start` in the same cycle as `done`: ignored, because `busy` is still high in that cycle. A new request is accepted from the following cycle.
- Reset mid-operation: next state IDLE, all outputs cleared, the pending result is discarded and `done` is not pulsed.

## Timing
- Let `start` be accepted at rising edge k.
- `busy` is high from k through the edge that raises `done`.
- Normal divide: `done` is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles of latency (1 load, WIDTH iterations, 1 fix).
- Divide-by-zero: `done` is high in the cycle after edge k+1.
- `done` lasts exactly one cycle. `quotient`, `remainder` and `div_by_zero` update in the same cycle that `done` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SEQ_DIVIDER_SIGNED_EN` defined: `is_signed` is honoured; the abs/negate logic and the FIX sign correction are present.
- Not defined: `is_signed` is ignored and every divide is unsigned. The FIX state still exists as a one-cycle pass-through, so latency is identical in both builds.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, RUN, FIX, ZERO}
  - counter width constant `CNT_W = $clog2(WIDTH+1)`
- Sub-module `div_step`: one combinational restoring iteration (shift, compare, subtract, emit quotient bit), parametrised by WIDTH. `seq_divider` owns the registers, the counter and the FSM.

## Test plan
- Unsigned 20 ÷ 5 → `quotient`=4, `remainder`=0, `done` at exactly WIDTH+2 cycles, `busy` high throughout.
- Back-to-back unsigned divides: 2000 ÷ 50 → 40 r 0; 19 ÷ 6 → 3 r 1; 34 ÷ 3 → 11 r 1. Each new `start` is issued the cycle after `done`.
- Divide-by-zero: 123 ÷ 0 → `done` after 2 cycles, `quotient`=0, `remainder`=123, `div_by_zero`=1. A following 9 ÷ 3 clears the flag and returns 3 r 0.
- Signed (macro defined): −7 ÷ 2 → −3 r −1; 7 ÷ −2 → −3 r 1; most-negative ÷ −1 → most-negative r 0.
- `start` pulsed mid-RUN with different operands → ignored; the original result is returned at the original time.
- `rst_n` low mid-RUN for 1 cycle → outputs 0, no `done`. A fresh 100 ÷ 7 then returns 14 r 2.
